dmem_responder: RTL and testbench

- Data-memory responder: the memory-side end of the MEM-stage load/store interface.
- Accepts one request at a time from the pipeline's memory stage through a valid/ready handshake.
- Performs byte/half/word stores with little-endian lane placement, and loads with sign or zero extension.
- Returns a response (read data plus error flag) after a fixed, parameterised latency; the pipeline stalls on it through the hazard unit.

---
 rtl/dmem_pkg.sv | 9 +
 rtl/dmem_lane_align.sv | 25 ++
 rtl/dmem_responder.sv | 93 +++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size/extension encodings shared with the control unit, and the responder state type
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic EXT_SIGNED = 1'b0;
  localparam logic EXT_UNSIGNED = 1'b1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: little-endian store lane placement, load extraction/extension and misalignment check
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        s_us,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlanes,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [31:0] shifted;
  logic        sign;
  always_comb begin
    misalign = size == 2'b11 || (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'b00);
    be = size == SZ_BYTE ? 4'b0001 << offset : size == SZ_HALF ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlanes = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    shifted = rword >> {offset, 3'b000};
    sign = s_us == EXT_UNSIGNED ? 1'b0 : size == SZ_BYTE ? shifted[7] : shifted[15];
    rdata = size == SZ_BYTE ? {{24{sign}}, shifted[7:0]} : size == SZ_HALF ? {{16{sign}}, shifted[15:0]} : rword;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the MEM-stage load/store handshake with fixed response latency
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_access_sz,
  input  logic        req_s_us,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] lat_addr, lat_wdata, op_addr, op_wdata, wlanes, rdata;
  logic [1:0] lat_sz, op_sz;
  logic lat_s_us, lat_write, op_s_us, op_write;
  logic accept, commit, misalign, op_err;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  assign req_ready = state == IDLE && !reset;
  assign resp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  // With a one-cycle latency the commit happens on the accept edge, so the live request is the operand
  assign op_addr = state == IDLE ? req_addr : lat_addr;
  assign op_wdata = state == IDLE ? req_wdata : lat_wdata;
  assign op_sz = state == IDLE ? req_access_sz : lat_sz;
  assign op_s_us = state == IDLE ? req_s_us : lat_s_us;
  assign op_write = state == IDLE ? req_write : lat_write;
  assign commit = (state == BUSY && cnt == 4'd1) || (LATENCY == 1 && accept);
  assign op_err = misalign || |op_addr[31:AW+2];
  dmem_lane_align u_align (
    .offset   (op_addr[1:0]),
    .size     (op_sz),
    .s_us     (op_s_us),
    .wdata    (op_wdata),
    .rword    (mem[op_addr[AW+1:2]]),
    .be       (be),
    .wlanes   (wlanes),
    .rdata    (rdata),
    .misalign (misalign)
  );
  always_comb begin
    state_nx = state == IDLE ? (accept ? (LATENCY == 1 ? RESP : BUSY) : IDLE)
             : state == BUSY ? (cnt == 4'd1 ? RESP : BUSY)
             : (resp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_sz <= '0;
      lat_s_us <= 1'b0;
      lat_write <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= 4'(LATENCY - 1);
        lat_addr <= req_addr;
        lat_wdata <= req_wdata;
        lat_sz <= req_access_sz;
        lat_s_us <= req_s_us;
        lat_write <= req_write;
      end else if (state == BUSY) cnt <= cnt - 4'd1;
      if (commit) begin
        resp_rdata <= (op_write || op_err) ? '0 : rdata;
        resp_err <= op_err;
      end else if (resp_valid && resp_ready) begin
        resp_rdata <= '0;
        resp_err <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (commit && op_write && !op_err)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[op_addr[AW+1:2]][8*i +: 8] <= wlanes[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: byte-level reference model with per-cycle compare plus directed literal checks
module tb_dmem_responder;
  import dmem_pkg::*;
  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY = 2;
  logic clk, reset, req_valid, req_ready, req_write, req_s_us, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0] req_access_sz;
  int checks = 0, failures = 0, n_acc = 0;
  dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_access_sz(req_access_sz), .req_s_us(req_s_us),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: memory as individual bytes; a request resolves LATENCY cycles after acceptance
  logic [7:0] mb [int];
  bit pend, ov, oe, rdy;
  logic [31:0] od, pa, pd, v;
  logic [1:0] psz;
  logic pw, ps;
  int cyc = 0, due = 0, n;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pend = 0; ov = 0; od = '0; oe = 0;
    end else begin
      rdy = !pend && !ov;
      cyc++;
      if (ov && resp_ready) begin ov = 0; od = '0; oe = 0; end
      if (rdy && req_valid) begin
        pend = 1; due = cyc + LATENCY - 1;
        pw = req_write; pa = req_addr; pd = req_wdata; psz = req_access_sz; ps = req_s_us;
      end
      if (pend && cyc == due) begin
        pend = 0; ov = 1; od = '0;
        n = 1 << psz;
        oe = psz == 2'b11 || (pa % n) != 0 || (pa / 4) >= DEPTH_WORDS;
        if (!oe && pw) for (int i = 0; i < n; i++) mb[int'(pa) + i] = pd[8*i +: 8];
        if (!oe && !pw) begin
          v = '0;
          for (int i = 0; i < n; i++) v |= 32'(mb[int'(pa) + i]) << (8 * i);
          if (ps == EXT_SIGNED && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
          od = v;
        end
      end
    end
  end
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", 32'(resp_err), 0);
    end else begin
      chk("cyc_req_ready", 32'(req_ready), 32'(!pend && !ov));
      chk("cyc_resp_valid", 32'(resp_valid), 32'(ov));
      chk("cyc_resp_rdata", resp_rdata, od);
      chk("cyc_resp_err", 32'(resp_err), 32'(oe));
    end
  end
  always @(posedge clk) if (!reset && req_valid && req_ready) n_acc++;
  task automatic xfer(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic s, input logic [31:0] exp_d, input logic exp_e);
    int k;
    @(negedge clk);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_access_sz = sz; req_s_us = s;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) chk({nm, "_accept_timeout"}, 32'(k), 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0; req_write = !w; req_addr = ~a; req_wdata = ~d; req_access_sz = ~sz; req_s_us = !s;
    k = 1;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    chk({nm, "_latency"}, 32'(k), LATENCY);
    chk({nm, "_rdata"}, resp_rdata, exp_d);
    chk({nm, "_err"}, 32'(resp_err), 32'(exp_e));
    @(posedge clk);
  endtask
  int k, n0;
  logic [31:0] hd;
  initial begin
    reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    req_access_sz = SZ_WORD; req_s_us = 0; resp_ready = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    xfer("sw_10", 1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 32'h0, 0);
    xfer("lw_10", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEADBEEF, 0);
    xfer("lb_13", 0, 32'h13, 32'h0, SZ_BYTE, EXT_SIGNED, 32'hFFFFFFDE, 0);
    xfer("lbu_13", 0, 32'h13, 32'h0, SZ_BYTE, EXT_UNSIGNED, 32'h000000DE, 0);
    xfer("lh_10", 0, 32'h10, 32'h0, SZ_HALF, EXT_SIGNED, 32'hFFFFBEEF, 0);
    xfer("sb_11", 1, 32'h11, 32'hAAAAAA55, SZ_BYTE, 0, 32'h0, 0);
    xfer("lw_after_sb", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEAD55EF, 0);
    xfer("sh_12", 1, 32'h12, 32'hBBBB1234, SZ_HALF, 0, 32'h0, 0);
    xfer("lw_after_sh", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'h123455EF, 0);
    xfer("lhu_12", 0, 32'h12, 32'h0, SZ_HALF, EXT_UNSIGNED, 32'h00001234, 0);
    xfer("err_lw_12", 0, 32'h12, 32'h0, SZ_WORD, 0, 32'h0, 1);
    xfer("err_sh_13", 1, 32'h13, 32'hFFFFFFFF, SZ_HALF, 0, 32'h0, 1);
    xfer("err_sz11", 1, 32'h10, 32'hFFFFFFFF, 2'b11, 0, 32'h0, 1);
    xfer("err_range", 0, DEPTH_WORDS * 4, 32'h0, SZ_WORD, 0, 32'h0, 1);
    xfer("lw_after_err", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'h123455EF, 0);
    n0 = n_acc;
    @(negedge clk);
    resp_ready = 0; req_valid = 1; req_write = 0; req_addr = 32'h10; req_access_sz = SZ_WORD; req_s_us = 0;
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge clk); k++; end
    chk("hold_reached_resp", 32'(resp_valid), 1);
    hd = resp_rdata;
    chk("hold_rdata_first", hd, 32'h123455EF);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 1);
      chk("hold_rdata", resp_rdata, hd);
      chk("hold_err", 32'(resp_err), 0);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    resp_ready = 1;
    k = 0;
    while (n_acc < n0 + 2 && k < 20) begin @(negedge clk); k++; end
    req_valid = 0;
    chk("hold_second_accept", 32'(n_acc - n0), 2);
    repeat (LATENCY + 4) @(negedge clk);
    chk("hold_total_accepts", 32'(n_acc - n0), 2);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF; req_access_sz = SZ_WORD;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    #2;
    reset = 1; req_valid = 0;
    #1;
    chk("busy_rst_req_ready", 32'(req_ready), 0);
    chk("busy_rst_resp_valid", 32'(resp_valid), 0);
    chk("busy_rst_rdata", resp_rdata, 0);
    chk("busy_rst_err", 32'(resp_err), 0);
    repeat (2) @(negedge clk);
    reset = 0;
    xfer("lw_after_rst", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'h123455EF, 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
